// File: rtl/blink_rtc.sv
// -----------------------------------------------------------------------------
// blink_rtc -- real-time clock and timer-interrupt unit for the Blink gate array
//
// Divides mck into a tick, then counts ticks (tim0), seconds (tim1) and
// minutes (timm). Tick/second/minute events raise sticky status flags that can
// be masked onto irq. The CPU reaches the block through an 8-entry register
// window behind the Blink I/O decoder.
//
// Optional feature macro: BLINK_RTC_ALARM_EN
//   defined   : minute alarm register (addr 5/6/7 writes), status/mask bit 3
//   undefined : no alarm; writes to 5-7 ignored, bit 3 reads 0
//
// Ports
//   mck        in   master clock, all logic on posedge
//   rin        in   asynchronous active-high reset
//   reg_wr     in   register write strobe (1 cycle per access)
//   reg_rd     in   register read strobe (1 cycle per access)
//   reg_addr   in   register select [2:0]
//   reg_wdata  in   write data [7:0]
//   reg_rdata  out  registered read data [7:0], holds until the next read
//   irq        out  registered interrupt request, active-high
//
// Register map
//   0 CTRL R/W [0]=ien [1]=restim     1 TSTA R status / W write-1-to-clear
//   2 TMK  R/W event mask              3 TIM0 R ticks (read snapshots 4..7)
//   4 TIM1 R shadow seconds            5/6/7 TIM2/3/4 R shadow minutes bytes
// -----------------------------------------------------------------------------
module blink_rtc #(
  parameter int TICK_DIV      = 49152,
  parameter int TICKS_PER_SEC = 200,
  parameter int SEC_PER_MIN   = 60,
  parameter int MIN_W         = 21
) (
  input  logic       mck,
  input  logic       rin,
  input  logic       reg_wr,
  input  logic       reg_rd,
  input  logic [2:0] reg_addr,
  input  logic [7:0] reg_wdata,
  output logic [7:0] reg_rdata,
  output logic       irq
);

  localparam int                PDIV_W   = $clog2(TICK_DIV);
  localparam logic [PDIV_W-1:0] PDIV_MAX = PDIV_W'(TICK_DIV - 1);
  localparam logic [7:0]        TIM0_MAX = 8'(TICKS_PER_SEC - 1);
  localparam logic [5:0]        TIM1_MAX = 6'(SEC_PER_MIN - 1);

`ifdef BLINK_RTC_ALARM_EN
  localparam logic [3:0] FLAG_MASK = 4'hF;
`else
  localparam logic [3:0] FLAG_MASK = 4'h7;
`endif

  typedef enum logic [2:0] {
    A_CTRL = 3'd0,
    A_TSTA = 3'd1,
    A_TMK  = 3'd2,
    A_TIM0 = 3'd3,
    A_TIM1 = 3'd4,
    A_TIM2 = 3'd5,
    A_TIM3 = 3'd6,
    A_TIM4 = 3'd7
  } reg_addr_e;

  logic              ien;
  logic              restim;
  logic [3:0]        tsta;
  logic [3:0]        tmk;
  logic [PDIV_W-1:0] pdiv;
  logic [7:0]        tim0;
  logic [5:0]        tim1;
  logic [MIN_W-1:0]  timm;
  logic [5:0]        sh_tim1;
  logic [MIN_W-1:0]  sh_timm;

  logic              wr_ctrl;
  logic              wr_tsta;
  logic              wr_tmk;
  logic              tick_ev;
  logic              sec_ev;
  logic              min_ev;
  logic              alarm_ev;
  logic [MIN_W-1:0]  timm_inc;
  logic [3:0]        flag_set;
  logic [3:0]        flag_clr;
  logic [23:0]       sh_ext;
  logic [7:0]        rd_mux;

  assign wr_ctrl = reg_wr & (reg_addr == A_CTRL);
  assign wr_tsta = reg_wr & (reg_addr == A_TSTA);
  assign wr_tmk  = reg_wr & (reg_addr == A_TMK);

  // Events cascade: a minute is always also a second and a tick.
  assign tick_ev  = ~restim & (pdiv == PDIV_MAX);
  assign sec_ev   = tick_ev & (tim0 == TIM0_MAX);
  assign min_ev   = sec_ev & (tim1 == TIM1_MAX);
  assign timm_inc = timm + MIN_W'(1);

`ifdef BLINK_RTC_ALARM_EN
  logic [MIN_W-1:0] alarm;
  // Compares against the value timm takes on this minute event.
  assign alarm_ev = min_ev & (timm_inc == alarm);
`else
  logic unused_wdata;
  assign alarm_ev     = 1'b0;
  assign unused_wdata = ^reg_wdata[7:4];
`endif

  // Setting a lower flag is implied by the cascade; set wins over a same-cycle TACK.
  assign flag_set = {alarm_ev, min_ev, sec_ev, tick_ev};
  assign flag_clr = wr_tsta ? (reg_wdata[3:0] & FLAG_MASK) : 4'h0;

  assign sh_ext = 24'(sh_timm);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    rd_mux = 8'h00;
    case (reg_addr)
      A_CTRL: rd_mux = {6'b0, restim, ien};
      A_TSTA: rd_mux = {4'b0, tsta};
      A_TMK:  rd_mux = {4'b0, tmk};
      A_TIM0: rd_mux = tim0;
      A_TIM1: rd_mux = {2'b0, sh_tim1};
      A_TIM2: rd_mux = sh_ext[7:0];
      A_TIM3: rd_mux = sh_ext[15:8];
      A_TIM4: rd_mux = sh_ext[23:16];
      default: rd_mux = 8'h00;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge mck or posedge rin) begin
    if (rin) begin
      ien       <= 1'b0;
      restim    <= 1'b0;
      tsta      <= 4'h0;
      tmk       <= 4'h0;
      pdiv      <= '0;
      tim0      <= 8'h00;
      tim1      <= 6'h00;
      timm      <= '0;
      sh_tim1   <= 6'h00;
      sh_timm   <= '0;
      reg_rdata <= 8'h00;
      irq       <= 1'b0;
`ifdef BLINK_RTC_ALARM_EN
      alarm     <= '1;
`endif
    end else begin
      if (wr_ctrl) {restim, ien} <= reg_wdata[1:0];
      if (wr_tmk)  tmk <= reg_wdata[3:0] & FLAG_MASK;

      if (restim) begin
        pdiv <= '0;
        tim0 <= 8'h00;
        tim1 <= 6'h00;
        timm <= '0;
        tsta <= 4'h0;
      end else begin
        tsta <= (tsta & ~flag_clr) | flag_set;
        pdiv <= tick_ev ? '0 : pdiv + 1'b1;
        if (tick_ev) begin
          if (sec_ev) begin
            tim0 <= 8'h00;
            if (min_ev) begin
              tim1 <= 6'h00;
              timm <= timm_inc;
            end else begin
              tim1 <= tim1 + 6'd1;
            end
          end else begin
            tim0 <= tim0 + 8'd1;
          end
        end
      end

      irq <= ien & |(tsta & tmk);

      if (reg_rd) begin
        reg_rdata <= rd_mux;
        // TIM0 read freezes seconds/minutes so a multi-byte read is coherent.
        if (reg_addr == A_TIM0) begin
          sh_tim1 <= tim1;
          sh_timm <= timm;
        end
      end

`ifdef BLINK_RTC_ALARM_EN
      if (reg_wr && reg_addr == A_TIM2) alarm[7:0]        <= reg_wdata;
      if (reg_wr && reg_addr == A_TIM3) alarm[15:8]       <= reg_wdata;
      if (reg_wr && reg_addr == A_TIM4) alarm[MIN_W-1:16] <= reg_wdata[MIN_W-17:0];
`endif
    end
  end

endmodule

// File: tb/tb_blink_rtc.sv
// -----------------------------------------------------------------------------
// tb_blink_rtc -- directed bench for blink_rtc with TICK_DIV=4, TICKS_PER_SEC=3,
// SEC_PER_MIN=2, MIN_W=17: a tick every 4 cycles, a second every 12, a minute
// every 24. Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_blink_rtc;

  logic       mck = 1'b0;
  logic       rin;
  logic       reg_wr;
  logic       reg_rd;
  logic [2:0] reg_addr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata;
  logic       irq;

  int tests_run = 0;
  int tests_failed = 0;

  blink_rtc #(
    .TICK_DIV      (4),
    .TICKS_PER_SEC (3),
    .SEC_PER_MIN   (2),
    .MIN_W         (17)
  ) dut (
    .mck       (mck),
    .rin       (rin),
    .reg_wr    (reg_wr),
    .reg_rd    (reg_rd),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .irq       (irq)
  );

  always #5 mck = ~mck;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 8'h%02h, expected 8'h%02h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge mck);
  endtask

  // One write; takes effect on the next rising edge, returns on the falling edge after it.
  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    reg_wr    = 1'b1;
    reg_addr  = a;
    reg_wdata = d;
    @(negedge mck);
    reg_wr    = 1'b0;
  endtask

  // One read; returns the register value as it was when the strobe was raised.
  task automatic rd(input logic [2:0] a, output logic [7:0] d);
    reg_rd   = 1'b1;
    reg_addr = a;
    @(negedge mck);
    reg_rd   = 1'b0;
    d        = reg_rdata;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    rin = 1'b1; reg_wr = 1'b0; reg_rd = 1'b0; reg_addr = 3'd0; reg_wdata = 8'h00;
    cyc(2);
    check("reset_rdata", reg_rdata, 8'h00);
    check("reset_irq", 8'(irq), 8'h00);
    rin = 1'b0;                              // E0: next rising edge is E1

    // 1. first tick on E4, irq stays low with ien=0
    cyc(3);
    rd(3'd1, v); check("tsta_before_tick", v, 8'h00);
    rd(3'd1, v); check("tsta_first_tick", v, 8'h01);
    check("irq_ien_off", 8'(irq), 8'h00);
    rd(3'd3, v); check("tim0_after_tick", v, 8'h01);

    // 2. mask and enable; tick on E8 raises irq at E9; TACK drops it two edges on
    wr(3'd2, 8'h01);
    wr(3'd0, 8'h01);
    check("irq_not_yet", 8'(irq), 8'h00);
    cyc(1);
    check("irq_rise", 8'(irq), 8'h01);
    wr(3'd1, 8'h01);
    check("irq_still_high", 8'(irq), 8'h01);
    cyc(1);
    check("irq_after_tack", 8'(irq), 8'h00);

    // resynchronise phase with restim; F0 is the edge that clears it
    wr(3'd0, 8'h02);
    wr(3'd0, 8'h00);

    // 3. 24 cycles -> one minute
    cyc(24);
    rd(3'd1, v); check("tsta_min", v, 8'h07);
    rd(3'd3, v); check("tim0_min", v, 8'h00);
    rd(3'd4, v); check("tim1_min", v, 8'h00);
    rd(3'd5, v); check("tim2_min", v, 8'h01);
    rd(3'd6, v); check("tim3_min", v, 8'h00);
    rd(3'd7, v); check("tim4_min", v, 8'h00);

    // 4. TACK on the tick edge F32: bit0 survives, others clear
    cyc(1);
    wr(3'd1, 8'h07);
    rd(3'd1, v); check("tack_vs_tick", v, 8'h01);
    wr(3'd1, 8'h07);
    rd(3'd1, v); check("tack_plain", v, 8'h00);
    cyc(1);
    rd(3'd1, v); check("tsta_sec", v, 8'h03);

    // 5. restim mid-count holds everything at zero
    wr(3'd0, 8'h02);
    cyc(1);
    rd(3'd3, v); check("restim_tim0", v, 8'h00);
    rd(3'd4, v); check("restim_tim1", v, 8'h00);
    rd(3'd5, v); check("restim_tim2", v, 8'h00);
    rd(3'd1, v); check("restim_tsta", v, 8'h00);
    cyc(4);
    rd(3'd1, v); check("restim_no_events", v, 8'h00);
    wr(3'd0, 8'h00);                          // G0
    rd(3'd1, v); check("restart_g0", v, 8'h00);
    cyc(2);
    rd(3'd1, v); check("restart_g3", v, 8'h00);
    rd(3'd1, v); check("restart_first_tick", v, 8'h01);

    // mask changes drop irq; sec flag with sec-only mask raises it
    wr(3'd0, 8'h01);
    wr(3'd2, 8'h00);
    check("irq_mask_on", 8'(irq), 8'h01);
    cyc(1);
    check("irq_mask_off", 8'(irq), 8'h00);
    wr(3'd2, 8'h02);
    check("irq_sec_mask_wait", 8'(irq), 8'h00);
    cyc(3);
    check("irq_before_sec", 8'(irq), 8'h00);
    cyc(1);
    check("irq_sec", 8'(irq), 8'h01);
    wr(3'd2, 8'hFF);
`ifdef BLINK_RTC_ALARM_EN
    rd(3'd2, v); check("tmk_readback", v, 8'h0F);
`else
    rd(3'd2, v); check("tmk_readback", v, 8'h07);
`endif
    rd(3'd0, v); check("ctrl_readback", v, 8'h01);

    // asynchronous reset mid-count
    #2 rin = 1'b1;
    #1;
    check("async_rst_irq", 8'(irq), 8'h00);
    check("async_rst_rdata", reg_rdata, 8'h00);
    @(negedge mck);
    rin = 1'b0;
    rd(3'd3, v); check("post_rst_tim0", v, 8'h00);
    rd(3'd0, v); check("post_rst_ctrl", v, 8'h00);
    rd(3'd2, v); check("post_rst_tmk", v, 8'h00);

`ifdef BLINK_RTC_ALARM_EN
    // 6. alarm at minute 2 (edge H48), irq at H49
    rin = 1'b1;
    @(negedge mck);
    rin = 1'b0;                               // H0
    wr(3'd5, 8'h02);
    wr(3'd6, 8'h00);
    wr(3'd7, 8'h00);
    wr(3'd2, 8'h08);
    wr(3'd0, 8'h01);
    cyc(20);
    check("alarm_not_min1", 8'(irq), 8'h00);
    cyc(23);
    check("alarm_before", 8'(irq), 8'h00);
    cyc(1);
    check("alarm_irq", 8'(irq), 8'h01);
    rd(3'd1, v); check("alarm_tsta", v, 8'h0F);
    wr(3'd1, 8'h08);
    rd(3'd1, v); check("alarm_tack", v, 8'h07);
`else
    // alarm writes have no effect; bit 3 never appears
    wr(3'd5, 8'hAA);
    wr(3'd1, 8'h08);
    rd(3'd1, v); check("no_alarm_bit3", v & 8'h08, 8'h00);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
